// File: rtl/text_fetch_seq.sv
// Per-line text-mode fetch scheduler: text RAM -> font ROM -> back half of the line buffer.
// Optional underline cursor is compiled in by defining TEXT_CURSOR_EN.
module text_fetch_seq #(
    parameter int NUM_CHARS = 32,
    parameter int H_ACTIVE  = 640,
    parameter int H_TOTAL   = 800,
    parameter int V_ACTIVE  = 480,
    parameter int V_TOTAL   = 525
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [9:0]  PIXEL_CNTR,
    input  logic [9:0]  ROW_NUM,
    output logic [10:0] TXT_ADDR,
    input  logic [7:0]  TXT_DATA,
    output logic        FONT_REQ,
    output logic [7:0]  FONT_CHAR,
    output logic [3:0]  FONT_ROW,
    input  logic [9:0]  FONT_DATA,
    output logic        LB_WE,
    output logic [5:0]  LB_CHAR_NUM,
    output logic [9:0]  LB_DATA,
    output logic        LB_SWAP,
    output logic        BUSY,
    output logic        OVERRUN
`ifdef TEXT_CURSOR_EN
    ,
    input  logic [5:0]  CURSOR_SLOT,
    input  logic        CURSOR_ON
`endif
);

    localparam logic [9:0] H_START   = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS     = 10'(V_ACTIVE);
    localparam logic [5:0] LAST_SLOT = 6'(NUM_CHARS - 1);

    typedef enum logic [2:0] {
        IDLE,
        TXT,
        CAP,
        FNT,
        WR,
        DONE
    } state_t;

    state_t     state;
    logic [5:0] slot;
    logic [4:0] text_row;
    logic [3:0] glyph_row;
    logic [9:0] tgt;
    logic       line_end;
    logic       fetching;

`ifdef TEXT_CURSOR_EN
    function automatic logic [9:0] lb_pixels(input logic [9:0] font, input logic [5:0] slot_i,
                                             input logic [3:0] grow, input logic [5:0] cslot,
                                             input logic con);
        return (con && (slot_i == cslot) && (grow >= 4'd14)) ? 10'h3FF : font;
    endfunction
`else
    function automatic logic [9:0] lb_pixels(input logic [9:0] font);
        return font;
    endfunction
`endif

    // The row being fetched is the one after the row currently scanned out.
    always_comb begin
        tgt      = (ROW_NUM == V_LAST) ? 10'd0 : ROW_NUM + 10'd1;
        line_end = (PIXEL_CNTR == H_LAST);
        fetching = (state == TXT) || (state == CAP) || (state == FNT) || (state == WR);
    end

    // Outputs are loaded together with the state they belong to, so they are
    // valid in the same cycle the FSM sits in that state.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state       <= IDLE;
            slot        <= 6'd0;
            text_row    <= 5'd0;
            glyph_row   <= 4'd0;
            TXT_ADDR    <= 11'd0;
            FONT_REQ    <= 1'b0;
            FONT_CHAR   <= 8'd0;
            FONT_ROW    <= 4'd0;
            LB_WE       <= 1'b0;
            LB_CHAR_NUM <= 6'd0;
            LB_DATA     <= 10'd0;
            LB_SWAP     <= 1'b0;
            BUSY        <= 1'b0;
            OVERRUN     <= 1'b0;
        end else begin
            FONT_REQ <= 1'b0;
            LB_WE    <= 1'b0;
            LB_SWAP  <= 1'b0;
            if (line_end && fetching) begin
                // Blanking ran out mid-fetch: drop the line and keep the old front buffer.
                OVERRUN <= 1'b1;
                BUSY    <= 1'b0;
                state   <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if ((PIXEL_CNTR == H_START) && (tgt < V_VIS)) begin
                            slot      <= 6'd0;
                            text_row  <= tgt[8:4];
                            glyph_row <= tgt[3:0];
                            TXT_ADDR  <= {tgt[8:4], 6'd0};
                            BUSY      <= 1'b1;
                            state     <= TXT;
                        end
                    end
                    TXT: begin
                        state <= CAP;
                    end
                    CAP: begin
                        // FONT_CHAR doubles as the character register.
                        FONT_CHAR <= TXT_DATA;
                        FONT_ROW  <= glyph_row;
                        FONT_REQ  <= 1'b1;
                        state     <= FNT;
                    end
                    FNT: begin
                        LB_WE       <= 1'b1;
                        LB_CHAR_NUM <= slot;
`ifdef TEXT_CURSOR_EN
                        LB_DATA     <= lb_pixels(FONT_DATA, slot, glyph_row, CURSOR_SLOT, CURSOR_ON);
`else
                        LB_DATA     <= lb_pixels(FONT_DATA);
`endif
                        state       <= WR;
                    end
                    WR: begin
                        if (slot == LAST_SLOT) begin
                            BUSY  <= 1'b0;
                            state <= DONE;
                        end else begin
                            slot     <= slot + 6'd1;
                            TXT_ADDR <= {text_row, slot + 6'd1};
                            state    <= TXT;
                        end
                    end
                    DONE: begin
                        if (line_end) begin
                            LB_SWAP <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                    default: begin
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_text_fetch_seq.sv
// Bench for text_fetch_seq: two instances (4 and 48 slots) driven through whole line windows
// against a slot-timing model; cursor checks compile in with TEXT_CURSOR_EN.
module tb_text_fetch_seq;

    localparam int NI       = 2;
    localparam int H_ACTIVE = 640;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [9:0] PIXEL_CNTR = 10'd0;
    logic [9:0] ROW_NUM = 10'd0;

    logic [10:0] txt_addr[NI];
    logic [7:0]  txt_data[NI];
    logic        font_req[NI];
    logic [7:0]  font_char[NI];
    logic [3:0]  font_row[NI];
    logic [9:0]  font_data[NI];
    logic        lb_we[NI];
    logic [5:0]  lb_char_num[NI];
    logic [9:0]  lb_data[NI];
    logic        lb_swap[NI];
    logic        busy[NI];
    logic        overrun[NI];
`ifdef TEXT_CURSOR_EN
    logic [5:0]  cursor_slot = 6'd0;
    logic        cursor_on = 1'b0;
`endif

    logic [7:0] txt_mem[2048];
    int compared = 0;
    int mismatched = 0;

    logic [9:0] tgt_row;
    logic       fetch_line;
    int         rst_pix;
    int         wr_cnt[NI];
    int         req_cnt[NI];
    int         swap_cnt[NI];
    int         multi_cnt[NI];
    logic       exp_ovr[NI];

    always #5 CLK = ~CLK;

    function automatic int nch(input int k);
        return (k == 0) ? 4 : 48;
    endfunction

    function automatic logic [9:0] font_fn(input logic [7:0] ch, input logic [3:0] r);
        return {r, 6'b0} ^ {2'b0, ch} ^ {ch[4:0], r, ch[0]};
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [7:0] td;
        text_fetch_seq #(
            .NUM_CHARS((g == 0) ? 4 : 48),
            .H_ACTIVE (H_ACTIVE),
            .H_TOTAL  (H_TOTAL),
            .V_ACTIVE (V_ACTIVE),
            .V_TOTAL  (V_TOTAL)
        ) u_dut (
            .CLK        (CLK),
            .RESET      (RESET),
            .PIXEL_CNTR (PIXEL_CNTR),
            .ROW_NUM    (ROW_NUM),
            .TXT_ADDR   (txt_addr[g]),
            .TXT_DATA   (txt_data[g]),
            .FONT_REQ   (font_req[g]),
            .FONT_CHAR  (font_char[g]),
            .FONT_ROW   (font_row[g]),
            .FONT_DATA  (font_data[g]),
            .LB_WE      (lb_we[g]),
            .LB_CHAR_NUM(lb_char_num[g]),
            .LB_DATA    (lb_data[g]),
            .LB_SWAP    (lb_swap[g]),
            .BUSY       (busy[g]),
            .OVERRUN    (overrun[g])
`ifdef TEXT_CURSOR_EN
            ,
            .CURSOR_SLOT(cursor_slot),
            .CURSOR_ON  (cursor_on)
`endif
        );
        // Text RAM answers one cycle after the address; the font ROM follows its address.
        always_ff @(posedge CLK) td <= txt_mem[txt_addr[g]];
        assign txt_data[g]  = td;
        assign font_data[g] = font_fn(font_char[g], font_row[g]);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] exp_pix(input int s);
        logic [9:0] f;
        f = font_fn(txt_mem[{tgt_row[8:4], 6'(s)}], tgt_row[3:0]);
`ifdef TEXT_CURSOR_EN
        if (cursor_on && (6'(s) == cursor_slot) && (tgt_row[3:0] >= 4'd14)) f = 10'h3FF;
`endif
        return f;
    endfunction

    // Slot s: TXT visible at H_ACTIVE+1+4s, FONT_REQ at +3+4s, LB_WE at +4+4s.
    task automatic monitor(input int k, input int p);
        int s;
        int ns;
        int last_busy;
        logic bexp;
        ns = int'(lb_we[k]) + int'(font_req[k]) + int'(lb_swap[k]);
        if (ns > 1) multi_cnt[k]++;
        if (font_req[k] === 1'b1) begin
            s = req_cnt[k];
            chk("font_req", 64'({10'(p), font_char[k], font_row[k]}),
                64'({10'(H_ACTIVE + 3 + 4 * s), txt_mem[{tgt_row[8:4], 6'(s)}], tgt_row[3:0]}));
            req_cnt[k]++;
        end
        if (lb_we[k] === 1'b1) begin
            s = wr_cnt[k];
            chk("lb_write", 64'({10'(p), lb_char_num[k], lb_data[k], txt_addr[k]}),
                64'({10'(H_ACTIVE + 4 + 4 * s), 6'(s), exp_pix(s), tgt_row[8:4], 6'(s)}));
            wr_cnt[k]++;
        end
        if (lb_swap[k] === 1'b1) swap_cnt[k]++;
        if (p == 650 || p == 700) begin
            last_busy = (H_ACTIVE + 4 + 4 * (nch(k) - 1) <= H_TOTAL - 1) ?
                        H_ACTIVE + 4 + 4 * (nch(k) - 1) : H_TOTAL - 1;
            bexp = fetch_line && (p <= last_busy) && (rst_pix < 0 || p <= rst_pix);
            chk("busy", 64'(busy[k]), 64'(bexp));
        end
    endtask

    task automatic step(input int p, input logic [9:0] row, input logic rst);
        @(posedge CLK);
        #1;
        PIXEL_CNTR = 10'(p);
        ROW_NUM    = row;
        RESET      = rst;
        @(negedge CLK);
        for (int k = 0; k < NI; k++) monitor(k, p);
    endtask

    // One window: fetch decision at pixel H_ACTIVE of row r through pixel H_ACTIVE-1 of the next row.
    task automatic run_window(input logic [9:0] r, input int rp);
        logic [9:0] nr;
        int cutoff;
        int n_wr;
        int n_req;
        nr = (r == 10'(V_TOTAL - 1)) ? 10'd0 : r + 10'd1;
        tgt_row    = nr;
        fetch_line = (int'(nr) < V_ACTIVE);
        rst_pix    = rp;
        for (int k = 0; k < NI; k++) begin
            wr_cnt[k] = 0; req_cnt[k] = 0; swap_cnt[k] = 0; multi_cnt[k] = 0;
        end
        for (int p = H_ACTIVE; p < H_TOTAL; p++) step(p, r, (p == rp) ? 1'b0 : 1'b1);
        for (int p = 0; p < H_ACTIVE; p++) step(p, nr, 1'b1);
        cutoff = (rp >= 0) ? rp : H_TOTAL - 1;
        for (int k = 0; k < NI; k++) begin
            n_wr = 0;
            n_req = 0;
            if (fetch_line) begin
                for (int s = 0; s < nch(k); s++) begin
                    if (H_ACTIVE + 4 + 4 * s <= cutoff) n_wr++;
                    if (H_ACTIVE + 3 + 4 * s <= cutoff) n_req++;
                end
            end
            if (rp >= 0) exp_ovr[k] = 1'b0;
            else if (fetch_line && n_wr < nch(k)) exp_ovr[k] = 1'b1;
            chk("write_count", 64'(wr_cnt[k]), 64'(n_wr));
            chk("req_count", 64'(req_cnt[k]), 64'(n_req));
            chk("swap_count", 64'(swap_cnt[k]),
                64'((fetch_line && rp < 0 && n_wr == nch(k)) ? 1 : 0));
            chk("overrun", 64'(overrun[k]), 64'(exp_ovr[k]));
            chk("strobe_overlap", 64'(multi_cnt[k]), 64'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) txt_mem[i] = 8'($urandom);
        for (int k = 0; k < NI; k++) exp_ovr[k] = 1'b0;
        tgt_row = 10'd0;
        fetch_line = 1'b0;
        rst_pix = -1;

        for (int i = 0; i < 3; i++) step(H_ACTIVE, 10'd17, 1'b0);
        for (int k = 0; k < NI; k++)
            chk("reset_outputs", 64'({txt_addr[k], font_req[k], font_char[k], font_row[k], lb_we[k],
                                     lb_char_num[k], lb_data[k], lb_swap[k], busy[k], overrun[k]}), 64'd0);
        step(100, 10'd17, 1'b1);
        step(101, 10'd17, 1'b1);
        for (int k = 0; k < NI; k++)
            chk("idle_after_reset", 64'({busy[k], font_req[k], lb_we[k], lb_swap[k], txt_addr[k]}), 64'd0);

        run_window(10'd17, -1);
        run_window(10'd524, -1);
        run_window(10'd479, -1);
        run_window(10'd500, -1);
        run_window(10'd30, H_ACTIVE + 7);
        run_window(10'd40, -1);
`ifdef TEXT_CURSOR_EN
        cursor_on = 1'b1;
        cursor_slot = 6'd2;
        run_window(10'd13, -1);
        run_window(10'd12, -1);
        cursor_on = 1'b0;
`endif
        for (int i = 0; i < 16; i++) begin
`ifdef TEXT_CURSOR_EN
            cursor_on = 1'($urandom);
            cursor_slot = 6'($urandom_range(0, 3));
`endif
            run_window(10'($urandom_range(0, V_TOTAL - 1)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
